// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the fetch stage, its PC register and the
// fetch-stage bus interface.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Byte distance between consecutive instructions.
  localparam word_t PC_INC = 32'd4;

  // Encoding of sll $0,$0,0; used as the bubble instruction in IF/ID.
  localparam word_t NOP_WORD = 32'h0000_0000;

  // Address of the next sequential instruction, wrapping modulo 2^32.
  function automatic word_t pc_next_seq(input word_t pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: hazard/redirect controls
// from decode, the instruction-memory port and the IF/ID register outputs.
interface mips_fetch_stage_if;
  import mips_pkg::*;

  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t imem_addr;
  word_t imem_rdata;
  word_t if_id_instr;
  word_t if_id_pc4;
  logic  if_id_valid;
  logic  misalign;
  word_t fetch_count;

  // Environment side: hazard unit, decode stage and instruction memory.
  modport master (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, misalign, fetch_count
  );

  // Fetch-stage side.
  modport slave (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, misalign, fetch_count
  );

endinterface

// File: rtl/mips_pc_reg.sv
// Program counter register: loads a redirect target or steps to the next
// sequential word whenever enabled, and holds otherwise.
module mips_pc_reg
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  logic  i_load,
  input  word_t i_load_pc,
  output word_t o_pc,
  output word_t o_pc_plus4
);

  word_t r_pc;
  word_t w_pc_plus4;

  assign w_pc_plus4 = pc_next_seq(r_pc);

  // PC update; the load target arrives already word-aligned from the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= {RESET_PC[WORD_W-1:2], 2'b00};
    end else if (i_en) begin
      if (i_load) begin
        r_pc <= i_load_pc;
      end else begin
        r_pc <= w_pc_plus4;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address from the PC,
// chooses the next PC (sequential or redirect) and captures the fetched word
// into the IF/ID register, flushing it to a bubble when decode redirects.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input logic               clk,
  input logic               rst,
  mips_fetch_stage_if.slave bus
);

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_pc_en;

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_misalign;
  logic [31:0] r_count;

  // A stall freezes the PC even when a redirect is pending; decode re-presents
  // the redirect once the stall clears.
  assign w_pc_en  = ~bus.stall;
  assign w_target = {bus.redirect_pc[31:2], 2'b00};

  mips_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_pc_en),
    .i_load     (bus.redirect),
    .i_load_pc  (w_target),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  // IF/ID register, accepted-instruction counter and misalignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_WORD;
      r_pc4      <= 32'd0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= 32'd0;
    end else if (bus.stall) begin
      r_misalign <= 1'b0;
    end else if (bus.redirect) begin
      r_instr    <= NOP_WORD;
      r_pc4      <= 32'd0;
      r_valid    <= 1'b0;
      r_misalign <= |bus.redirect_pc[1:0];
    end else begin
      r_instr    <= bus.imem_rdata;
      r_pc4      <= w_pc_plus4;
      r_valid    <= 1'b1;
      r_misalign <= 1'b0;
      r_count    <= r_count + 32'd1;
    end
  end

  assign bus.imem_addr   = w_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc4   = r_pc4;
  assign bus.if_id_valid = r_valid;
  assign bus.misalign    = r_misalign;
  assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for the fetch stage: stimulus steps a behavioural model and
// queues the expected IF/ID state; a monitor compares whenever it falls due.
module tb_mips_fetch_stage;

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
    logic [31:0] count;
    string       tag;
  } exp_t;

  logic clk;
  logic rst;
  int   cycleCount;
  int   checks;
  int   passes;
  exp_t sbQ[$];
  event checkNow;

  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  logic        mValid;
  logic        mMis;
  logic [31:0] mCount;

  mips_fetch_stage_if bus ();

  mips_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Instruction memory contents: two fixed words, a hashed pattern elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
  endfunction

  assign bus.imem_rdata = memWord(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act === exp) passes = passes + 1;
    else $display("[TB] FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: pops every expectation that has fallen due and compares it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or checkNow);
      while (sbQ.size() > 0 && sbQ[0].due <= cycleCount) begin
        e = sbQ.pop_front();
        checkOutput({e.tag, ".imem_addr"}, bus.imem_addr, e.addr);
        checkOutput({e.tag, ".instr"}, bus.if_id_instr, e.instr);
        checkOutput({e.tag, ".pc4"}, bus.if_id_pc4, e.pc4);
        checkOutput({e.tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        checkOutput({e.tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, e.mis});
        checkOutput({e.tag, ".count"}, bus.fetch_count, e.count);
      end
    end
  end

  task automatic pushExpect(input int due, input string tag);
    exp_t e;
    e.due   = due;
    e.addr  = mPc;
    e.instr = mInstr;
    e.pc4   = mPc4;
    e.valid = mValid;
    e.mis   = mMis;
    e.count = mCount;
    e.tag   = tag;
    sbQ.push_back(e);
  endtask

  task automatic modelReset();
    mPc = 0; mInstr = 0; mPc4 = 0; mValid = 0; mMis = 0; mCount = 0;
  endtask

  // Called at a falling edge: drive controls, predict the next edge, then wait.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc, input string tag);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    if (st) begin
      mMis = 0;
    end else if (rd) begin
      mPc    = rpc - (rpc % 4);
      mInstr = 0;
      mPc4   = 0;
      mValid = 0;
      mMis   = (rpc % 4) != 0;
    end else begin
      mInstr = memWord(mPc);
      mPc    = mPc + 4;
      mPc4   = mPc;
      mValid = 1;
      mMis   = 0;
      mCount = mCount + 1;
    end
    pushExpect(cycleCount + 1, tag);
    @(negedge clk);
  endtask

  initial begin
    cycleCount      = 0;
    checks          = 0;
    passes          = 0;
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    modelReset();

    @(negedge clk);
    #3;
    pushExpect(cycleCount, "reset");
    ->checkNow;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 0, "seq0");
    applyStimulus(0, 0, 0, "seq1");
    repeat (3) applyStimulus(1, 0, 0, "stall");
    applyStimulus(0, 0, 0, "resume");
    applyStimulus(0, 0, 0, "seq2");
    applyStimulus(0, 1, 32'h40, "redir40");
    applyStimulus(0, 0, 0, "after40");
    repeat (2) applyStimulus(1, 1, 32'h80, "stallRedir");
    applyStimulus(0, 1, 32'h80, "redir80");
    applyStimulus(0, 0, 0, "after80");
    applyStimulus(0, 1, 32'h42, "mis42");
    applyStimulus(0, 0, 0, "misDrop");
    applyStimulus(0, 1, 32'hFFFF_FFFC, "toTop");
    applyStimulus(0, 0, 0, "wrap");
    applyStimulus(0, 0, 0, "postWrap");

    for (int i = 0; i < 80; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 4) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 1) == 1) rpc[1:0] = 2'b00;
      applyStimulus(st, rd, rpc, "rand");
    end

    applyStimulus(0, 1, 32'h20, "to20");
    applyStimulus(0, 0, 0, "at24");

    // Asynchronous reset in the middle of a stalled cycle at pc 0x24.
    bus.stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    pushExpect(cycleCount, "asyncRst");
    ->checkNow;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.stall = 1'b0;

    applyStimulus(0, 0, 0, "rst0");
    applyStimulus(0, 0, 0, "rst1");

    #1;
    checks = checks + 1;
    if (sbQ.size() == 0) passes = passes + 1;
    else $display("[TB] FAIL drain: got %0d pending required 0", sbQ.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch stage of the 32-bit MIPS core: holds the program counter, drives the instruction-memory address, selects the next PC (sequential, branch, jump), and registers the fetched word into the IF/ID pipeline register consumed by the decode stage. It sits directly upstream of decode/register-file read inside the `MIPS_32_BITS` top. Stall and flush controls come from the hazard unit and the ID-stage branch/jump resolution.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `NOP_WORD`, default 32'h0000_0000: instruction injected into IF/ID on flush/reset (`sll $0,$0,0`).

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `redirect`  in  1  ID stage: taken branch or jump this cycle.
- `redirect_pc`  in  32  target byte address for `redirect`.
- `imem_addr`  out  32  byte address to instruction memory (combinational from PC).
- `imem_rdata`  in  32  instruction word, combinational read of `imem_addr`.
- `if_id_instr`  out  32  registered instruction to ID.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `misalign`  out  1  registered one-cycle pulse: `redirect_pc[1:0] != 0` was accepted.
- `fetch_count`  out  32  number of instructions accepted into IF/ID since reset.

## Operation

- `imem_addr = pc` at all times; memory indexes with `[31:2]`.
- Per rising edge, priority (highest first):
  1. `stall`=1: `pc`, IF/ID, `fetch_count` hold; `redirect` ignored (ID holds too and re-presents it next cycle); `misalign` = 0.
  2. `redirect`=1: `pc <= {redirect_pc[31:2],2'b00}`; IF/ID <= `NOP_WORD`, `if_id_pc4` <= 0, `if_id_valid` <= 0 (flush of wrong-path fetch); `misalign <= |redirect_pc[1:0]`; count holds.
  3. otherwise: `pc <= pc + 4` (modulo 2^32, 32'hFFFF_FFFC wraps to 0); `if_id_instr <= imem_rdata`, `if_id_pc4 <= pc + 4`, `if_id_valid <= 1`, `fetch_count <= fetch_count + 1` (wraps at 2^32); `misalign` = 0.
- No FSM beyond the PC register; `pc` bits [1:0] are always 0.

## Timing

- Reset (async, immediate on `rst` rise, held while high): `pc = RESET_PC`, `if_id_instr = NOP_WORD`, `if_id_pc4 = 0`, `if_id_valid = 0`, `misalign = 0`, `fetch_count = 0`; `imem_addr = RESET_PC` combinationally.
- First edge after `rst` falls with no stall/redirect: IF/ID = `mem[RESET_PC]`, valid=1, `pc = RESET_PC+4`.
- Fetch-to-ID latency: 1 cycle. Redirect penalty: 1 bubble (instruction behind the branch is squashed; no delay slot).
- Reset asserted mid-stall or mid-redirect: reset wins, all state as above.
- `stall` and `redirect` both high: stall wins; state unchanged.

## Structure

- Shared package `mips_pkg`: `NOP_WORD` constant, `WORD_W = 32`, `PC_INC = 4`, instruction word typedef.
- One sub-module natural: `mips_pc_reg` (PC register with async reset, enable, load), instantiated by the stage; IF/ID register and counter stay in the stage body.

## Test plan

- Reset release, memory words 0x20080005, 0x20090003 at 0x0, 0x4 -> edge 1: `if_id_instr`=0x20080005, `if_id_pc4`=4, valid=1, `imem_addr`=4; edge 2: 0x20090003, pc4=8, `fetch_count`=2.
- `stall` high 3 cycles at pc=0x8 -> `pc`, IF/ID, count frozen for 3 edges; resumes at 0xC on release.
- `redirect`=1, `redirect_pc`=0x40 at pc=0x10 -> next edge: pc=0x40, valid=0, instr=0x00000000, count unchanged; following edge fetches `mem[0x40]`, pc4=0x44.
- `stall` and `redirect` together (target 0x80) -> no change; stall drops with redirect still high -> pc=0x80, bubble.
- `redirect_pc`=0x42 -> pc=0x40, `misalign` high exactly one cycle; pc starting at 0xFFFF_FFFC sequential -> pc wraps to 0, pc4 captured = 0.
- Assert `rst` asynchronously mid-cycle at pc=0x24 -> outputs at reset values before next edge; `fetch_count`=0.
